// File: rtl/multicycle_control_unit_pkg.sv
// rtl/multicycle_control_unit_pkg.sv - states, select encodings and opcode constants for the multi-cycle control unit
package multicycle_control_unit_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_R_EXEC,
    S_R_WB,
    S_I_EXEC,
    S_I_WB,
    S_BRANCH,
    S_JUMP,
    S_JUMP_REG,
    S_MULDIV,
    S_ILLEGAL
  } state_t;

  localparam logic [1:0] PC_PLUS4   = 2'b00;
  localparam logic [1:0] PC_BRANCH  = 2'b01;
  localparam logic [1:0] PC_JUMP    = 2'b10;
  localparam logic [1:0] PC_JR      = 2'b11;

  localparam logic [1:0] WA_RT      = 2'b00;
  localparam logic [1:0] WA_RD      = 2'b01;
  localparam logic [1:0] WA_R31     = 2'b10;

  localparam logic       ALU_A_PC   = 1'b0;
  localparam logic       ALU_A_RS   = 1'b1;

  localparam logic [1:0] ALU_B_RT   = 2'b00;
  localparam logic [1:0] ALU_B_FOUR = 2'b01;
  localparam logic [1:0] ALU_B_IMM  = 2'b10;
  localparam logic [1:0] ALU_B_BOFF = 2'b11;

  localparam logic [1:0] RES_ALU    = 2'b00;
  localparam logic [1:0] RES_DMEM   = 2'b01;
  localparam logic [1:0] RES_PC4    = 2'b10;
  localparam logic [1:0] RES_HILO   = 2'b11;

  localparam logic [5:0] OPCODE_RTYPE = 6'h00;
  localparam logic [5:0] OPCODE_J     = 6'h02;
  localparam logic [5:0] OPCODE_JAL   = 6'h03;
  localparam logic [5:0] OPCODE_BEQ   = 6'h04;
  localparam logic [5:0] OPCODE_ADDI  = 6'h08;
  localparam logic [5:0] OPCODE_LW    = 6'h23;
  localparam logic [5:0] OPCODE_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_JR     = 6'h08;
  localparam logic [5:0] FUNCT_MFHI   = 6'h10;
  localparam logic [5:0] FUNCT_MFLO   = 6'h12;
  localparam logic [5:0] FUNCT_MULTU  = 6'h19;
  localparam logic [5:0] FUNCT_DIVU   = 6'h1B;
  localparam logic [5:0] FUNCT_ADD    = 6'h20;
  localparam logic [5:0] FUNCT_SUB    = 6'h22;
  localparam logic [5:0] FUNCT_OR     = 6'h25;
  localparam logic [5:0] FUNCT_SLT    = 6'h2A;

  // State that follows DECODE for a given instruction word.
  function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
    state_t ns;
    ns = S_ILLEGAL;
    case (op)
      OPCODE_LW, OPCODE_SW: ns = S_MEM_ADDR;
      OPCODE_ADDI:          ns = S_I_EXEC;
      OPCODE_BEQ:           ns = S_BRANCH;
      OPCODE_J, OPCODE_JAL: ns = S_JUMP;
      OPCODE_RTYPE: begin
        case (fn)
          FUNCT_ADD, FUNCT_SUB, FUNCT_OR, FUNCT_SLT,
          FUNCT_MFHI, FUNCT_MFLO:   ns = S_R_EXEC;
          FUNCT_JR:                 ns = S_JUMP_REG;
          FUNCT_MULTU, FUNCT_DIVU:  ns = S_MULDIV;
          default:                  ns = S_ILLEGAL;
        endcase
      end
      default: ns = S_ILLEGAL;
    endcase
    return ns;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_muldiv_counter.sv
// rtl/multicycle_control_unit_muldiv_counter.sv - load/decrement/done counter timing the MULDIV phase
module multicycle_control_unit_muldiv_counter #(
  parameter int CYCLES = 32,
  parameter int WIDTH  = $clog2(CYCLES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  localparam logic [WIDTH-1:0] LOAD_VAL = WIDTH'(CYCLES - 1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle MIPS control FSM with memory handshakes and counted mult/div phase
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] sel_pc,
  output logic       rf_we,
  output logic [1:0] sel_wa,
  output logic       sel_alu_a,
  output logic [1:0] sel_alu_b,
  output logic [1:0] sel_result,
  output logic       sel_hilo,
  output logic       muldiv_start,
  output logic       hilo_we,
  output logic       illegal
);

  localparam int CW = $clog2(MULDIV_CYCLES);
  localparam logic [CW-1:0] MD_FIRST = CW'(MULDIV_CYCLES - 1);

  state_t state, next_state, decoded;
  logic   mem_is_write;
  logic   imem_rdy, dmem_rdy;
  logic   md_load, md_dec, md_done;
  logic [CW-1:0] md_count;

  assign imem_rdy = MEM_HANDSHAKE ? imem_ready : 1'b1;
  assign dmem_rdy = MEM_HANDSHAKE ? dmem_ready : 1'b1;
  assign decoded  = decode_next(opcode, funct);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Load/store direction is captured at DECODE so MEM_ADDR does not depend on a live opcode.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_is_write <= 1'b0;
    end else if (state == S_DECODE) begin
      mem_is_write <= (opcode == OPCODE_SW);
    end
  end

  multicycle_control_unit_muldiv_counter #(
    .CYCLES(MULDIV_CYCLES),
    .WIDTH (CW)
  ) u_muldiv_counter (
    .clock(clock),
    .reset(reset),
    .load (md_load),
    .dec  (md_dec),
    .count(md_count),
    .done (md_done)
  );

  always_comb begin
    next_state   = state;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    sel_pc       = PC_PLUS4;
    rf_we        = 1'b0;
    sel_wa       = WA_RT;
    sel_alu_a    = ALU_A_PC;
    sel_alu_b    = ALU_B_RT;
    sel_result   = RES_ALU;
    sel_hilo     = 1'b0;
    muldiv_start = 1'b0;
    hilo_we      = 1'b0;
    illegal      = 1'b0;
    md_load      = 1'b0;
    md_dec       = 1'b0;

    case (state)
      S_IDLE: next_state = S_FETCH;

      S_FETCH: begin
        imem_req  = 1'b1;
        sel_alu_b = ALU_B_FOUR;
        if (imem_rdy) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          next_state = S_DECODE;
        end
      end

      S_DECODE: begin
        sel_alu_b  = ALU_B_BOFF;
        next_state = decoded;
        md_load    = (decoded == S_MULDIV);
      end

      S_MEM_ADDR: begin
        sel_alu_a  = ALU_A_RS;
        sel_alu_b  = ALU_B_IMM;
        next_state = mem_is_write ? S_MEM_WRITE : S_MEM_READ;
      end

      S_MEM_READ: begin
        dmem_req = 1'b1;
        if (dmem_rdy) next_state = S_MEM_WB;
      end

      S_MEM_WB: begin
        rf_we      = 1'b1;
        sel_wa     = WA_RT;
        sel_result = RES_DMEM;
        next_state = S_FETCH;
      end

      S_MEM_WRITE: begin
        dmem_req = 1'b1;
        dmem_we  = 1'b1;
        if (dmem_rdy) next_state = S_FETCH;
      end

      S_R_EXEC: begin
        sel_alu_a  = ALU_A_RS;
        sel_alu_b  = ALU_B_RT;
        next_state = S_R_WB;
      end

      S_R_WB: begin
        rf_we  = 1'b1;
        sel_wa = WA_RD;
        if (opcode == OPCODE_RTYPE && (funct == FUNCT_MFHI || funct == FUNCT_MFLO)) begin
          sel_result = RES_HILO;
          sel_hilo   = (funct == FUNCT_MFHI);
        end
        next_state = S_FETCH;
      end

      S_I_EXEC: begin
        sel_alu_a  = ALU_A_RS;
        sel_alu_b  = ALU_B_IMM;
        next_state = S_I_WB;
      end

      S_I_WB: begin
        rf_we      = 1'b1;
        sel_wa     = WA_RT;
        sel_result = RES_ALU;
        next_state = S_FETCH;
      end

      S_BRANCH: begin
        sel_alu_a  = ALU_A_RS;
        sel_alu_b  = ALU_B_RT;
        sel_pc     = PC_BRANCH;
        pc_we      = zero;
        next_state = S_FETCH;
      end

      S_JUMP: begin
        pc_we  = 1'b1;
        sel_pc = PC_JUMP;
        if (opcode == OPCODE_JAL) begin
          rf_we      = 1'b1;
          sel_wa     = WA_R31;
          sel_result = RES_PC4;
        end
        next_state = S_FETCH;
      end

      S_JUMP_REG: begin
        pc_we      = 1'b1;
        sel_pc     = PC_JR;
        next_state = S_FETCH;
      end

      // Counter holds MULDIV_CYCLES-1 only in the first MULDIV cycle, so that marks the start pulse.
      S_MULDIV: begin
        muldiv_start = (md_count == MD_FIRST);
        md_dec       = 1'b1;
        if (md_done) begin
          hilo_we    = 1'b1;
          next_state = S_FETCH;
        end
      end

      S_ILLEGAL: begin
        illegal    = 1'b1;
        next_state = S_FETCH;
      end

      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - randomized instruction-level bench for the multi-cycle control unit
module tb_multicycle_control_unit;

  localparam int N = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we;
  logic       sel_alu_a, sel_hilo, muldiv_start, hilo_we, illegal;
  logic [1:0] sel_pc, sel_wa, sel_alu_b, sel_result;
  logic [18:0] all_out;

  int total = 0;
  int bad = 0;

  multicycle_control_unit #(.MULDIV_CYCLES(N), .MEM_HANDSHAKE(1'b1)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we),
    .sel_pc(sel_pc), .rf_we(rf_we), .sel_wa(sel_wa), .sel_alu_a(sel_alu_a),
    .sel_alu_b(sel_alu_b), .sel_result(sel_result), .sel_hilo(sel_hilo),
    .muldiv_start(muldiv_start), .hilo_we(hilo_we), .illegal(illegal)
  );

  assign all_out = {imem_req, dmem_req, dmem_we, ir_we, pc_we, sel_pc, rf_we, sel_wa,
                    sel_alu_a, sel_alu_b, sel_result, sel_hilo, muldiv_start, hilo_we, illegal};

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Instruction kinds: 0 ALU, 1 MFHI, 2 MFLO, 3 ADDI, 4 LW, 5 SW, 6 BEQ, 7 J, 8 JAL, 9 JR, 10 MULDIV, 11 illegal
  int tbl_op [18] = '{'h00, 'h00, 'h00, 'h00, 'h00, 'h00, 'h08, 'h23, 'h2B,
                      'h04, 'h02, 'h03, 'h00, 'h00, 'h00, 'h3F, 'h00, 'h0F};
  int tbl_fn [18] = '{'h20, 'h22, 'h25, 'h2A, 'h10, 'h12, -1, -1, -1,
                      -1, -1, -1, 'h08, 'h19, 'h1B, -1, 'h00, -1};
  int tbl_k  [18] = '{0, 0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 10, 11, 11, 11};

  // Entered #1 after a rising edge with the DUT in FETCH; returns the same way at the next FETCH.
  task automatic run_instr(input int idx, input int ki, input int kd, input bit z);
    int k, e, base, mem_start;
    bit mem, scr;
    int e_pc, e_last_pc, e_rf, e_wa, e_res, e_hilo;
    int n_ir, c_ir, n_pc, last_pc, n_rf, c_rf, rf_wa, rf_res, rf_hilo;
    int n_ireq, n_dreq, n_dwe, n_st, c_st, n_hl, c_hl, n_ill;
    string nm;

    k   = tbl_k[idx];
    mem = (k == 4 || k == 5);
    scr = (k == 3 || k == 4 || k == 5 || k == 6 || k == 9 || k == 10 || k == 11);
    case (k)
      6, 7, 8, 9, 11: base = 3;
      4:              base = 5;
      10:             base = 2 + N;
      default:        base = 4;
    endcase
    e = base + ki + (mem ? kd : 0);
    mem_start = ki + 3;

    e_pc      = 1 + ((k == 6) ? int'(z) : (k == 7 || k == 8 || k == 9) ? 1 : 0);
    e_last_pc = (k == 6 && z) ? 1 : (k == 7 || k == 8) ? 2 : (k == 9) ? 3 : 0;
    e_rf      = (k <= 4 || k == 8) ? 1 : 0;
    e_wa      = (k == 8) ? 2 : (k <= 2) ? 1 : 0;
    e_res     = (k == 4) ? 1 : (k == 8) ? 2 : (k == 1 || k == 2) ? 3 : 0;
    e_hilo    = (k == 1) ? 1 : 0;

    n_ir = 0; c_ir = -1; n_pc = 0; last_pc = -1; n_rf = 0; c_rf = -1;
    rf_wa = -1; rf_res = -1; rf_hilo = -1; n_ireq = 0; n_dreq = 0; n_dwe = 0;
    n_st = 0; c_st = -1; n_hl = 0; c_hl = -1; n_ill = 0;

    opcode = 6'(tbl_op[idx]);
    funct  = (tbl_fn[idx] < 0) ? 6'($urandom) : 6'(tbl_fn[idx]);

    for (int c = 0; c < e; c++) begin
      imem_ready = (c < ki) ? 1'b0 : ((c == ki) ? 1'b1 : 1'($urandom));
      dmem_ready = mem ? (c >= mem_start + kd) : 1'($urandom);
      zero       = (k == 6 && c == ki + 2) ? z : 1'($urandom);
      if (scr && c == ki + 2) begin
        opcode = 6'($urandom);
        funct  = 6'($urandom);
      end
      @(negedge clock);
      if (ir_we) begin n_ir++; c_ir = c; end
      if (pc_we) begin n_pc++; last_pc = int'(sel_pc); end
      if (rf_we) begin n_rf++; c_rf = c; rf_wa = int'(sel_wa); rf_res = int'(sel_result); rf_hilo = int'(sel_hilo); end
      if (imem_req) n_ireq++;
      if (dmem_req) n_dreq++;
      if (dmem_we) n_dwe++;
      if (muldiv_start) begin n_st++; c_st = c; end
      if (hilo_we) begin n_hl++; c_hl = c; end
      if (illegal) n_ill++;
      @(posedge clock);
      #1;
    end

    nm = $sformatf("i%0d", idx);
    check({nm, " imem_req_cycles"}, n_ireq, ki + 1);
    check({nm, " ir_we_count"}, n_ir, 1);
    check({nm, " ir_we_cycle"}, c_ir, ki);
    check({nm, " pc_we_count"}, n_pc, e_pc);
    check({nm, " last_sel_pc"}, last_pc, e_last_pc);
    check({nm, " rf_we_count"}, n_rf, e_rf);
    if (e_rf == 1) begin
      check({nm, " rf_we_cycle"}, c_rf, e - 1);
      check({nm, " sel_wa"}, rf_wa, e_wa);
      check({nm, " sel_result"}, rf_res, e_res);
      check({nm, " sel_hilo"}, rf_hilo, e_hilo);
    end
    check({nm, " dmem_req_cycles"}, n_dreq, mem ? kd + 1 : 0);
    check({nm, " dmem_we_cycles"}, n_dwe, (k == 5) ? kd + 1 : 0);
    check({nm, " muldiv_start_count"}, n_st, (k == 10) ? 1 : 0);
    check({nm, " hilo_we_count"}, n_hl, (k == 10) ? 1 : 0);
    if (k == 10) begin
      check({nm, " muldiv_start_cycle"}, c_st, ki + 2);
      check({nm, " hilo_we_cycle"}, c_hl, e - 1);
    end
    check({nm, " illegal_count"}, n_ill, (k == 11) ? 1 : 0);
    check({nm, " next_fetch"}, int'(imem_req), 1);
  endtask

  task automatic release_reset();
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("idle_after_reset", int'(all_out), 0);
    @(posedge clock);
    #1;
    check("fetch_after_idle", int'(imem_req), 1);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_outputs", int'(all_out), 0);
    release_reset();

    run_instr(0, 0, 0, 1'b0);   // ADD, no stalls
    run_instr(7, 0, 3, 1'b0);   // LW, 3 dmem wait cycles
    run_instr(9, 0, 0, 1'b0);   // BEQ not taken
    run_instr(9, 1, 0, 1'b1);   // BEQ taken
    run_instr(11, 0, 0, 1'b0);  // JAL
    run_instr(14, 0, 0, 1'b0);  // DIVU
    run_instr(4, 2, 0, 1'b0);   // MFHI
    run_instr(15, 0, 0, 1'b0);  // opcode 0x3F
    run_instr(0, 1, 0, 1'b0);   // normal fetch after illegal

    // Abort a store stuck in MEM_WRITE with an asynchronous reset.
    opcode = 6'h2B;
    imem_ready = 1'b1;
    dmem_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("sw_stalled_dmem_we", int'(dmem_we), 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs", int'(all_out), 0);
    @(negedge clock);
    check("reset_held_outputs", int'(all_out), 0);
    release_reset();

    for (int n = 0; n < 60; n++) begin
      run_instr($urandom_range(17, 0), $urandom_range(3, 0), $urandom_range(3, 0), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
